// File: rtl/traffic_pkg.sv
// Shared types, light encodings and phase-length helper for the traffic sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_PV = 2'd0,
    S_PA = 2'd1,
    S_SV = 2'd2,
    S_SA = 2'd3
  } state_e;

  localparam logic [2:0] LIGHT_RED   = 3'b100;
  localparam logic [2:0] LIGHT_AMBER = 3'b010;
  localparam logic [2:0] LIGHT_GREEN = 3'b001;
  localparam logic [1:0] PED_RED     = 2'b10;
  localparam logic [1:0] PED_GREEN   = 2'b01;

  typedef struct packed {
    logic [2:0] prin_road;
    logic [2:0] sec_road;
    logic [1:0] prin_ped;
    logic [1:0] sec_ped;
  } lights_t;

  // A zero duration still yields a one-second phase so the countdown never reads 0.
  function automatic logic [6:0] max1(input logic [6:0] t);
    return (t == 7'd0) ? 7'd1 : t;
  endfunction

  function automatic lights_t decode_lights(input state_e s);
    lights_t l;
    l.prin_road = LIGHT_RED;
    l.sec_road  = LIGHT_RED;
    l.prin_ped  = PED_RED;
    l.sec_ped   = PED_RED;
    case (s)
      S_PV: begin
        l.prin_road = LIGHT_GREEN;
        l.sec_ped   = PED_GREEN;
      end
      S_PA: l.prin_road = LIGHT_AMBER;
      S_SV: begin
        l.sec_road = LIGHT_GREEN;
        l.prin_ped = PED_GREEN;
      end
      S_SA: l.sec_road = LIGHT_AMBER;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Timing inputs and light/LCD outputs between the sequencer and the LCD output stage.
interface traffic_sequencer_if;
  logic [6:0] Tpv;
  logic [6:0] Tsv;
  logic [6:0] Ta;
  logic       pedReq;
  logic [6:0] timeRemaining;
  logic [2:0] Principal_Road;
  logic [2:0] Secondary_Road;
  logic [1:0] Principal_Pedestrian;
  logic [1:0] Secondary_Pedestrian;
  logic [1:0] StateFlag;
  logic [1:0] PhraseSel;

  // Sequencer side: consumes durations and requests, drives lights and LCD fields.
  modport master (
    input  Tpv, Tsv, Ta, pedReq,
    output timeRemaining, Principal_Road, Secondary_Road,
    output Principal_Pedestrian, Secondary_Pedestrian, StateFlag, PhraseSel
  );

  modport slave (
    output Tpv, Tsv, Ta, pedReq,
    input  timeRemaining, Principal_Road, Secondary_Road,
    input  Principal_Pedestrian, Secondary_Pedestrian, StateFlag, PhraseSel
  );
endinterface

// File: rtl/second_tick_gen.sv
// One-second prescaler: single-cycle tick on the last count, restartable by clear.
module second_tick_gen #(
  parameter int unsigned CLK_PER_SEC = 50000000
) (
  input  logic clock50MHz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_SEC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road traffic-light phase sequencer with pedestrian shortening of the principal green.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 50000000,
  parameter logic [6:0]  PED_MIN     = 7'd5
) (
  input  logic                clock50MHz,
  input  logic                reset,
  traffic_sequencer_if.master bus
);

  state_e     state_q, state_d, state_nxt;
  logic [6:0] time_q, time_d, entry_len;
  lights_t    lights_q, lights_d;
  logic       tick, ped_hit, phase_done;

  second_tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick (
    .clock50MHz(clock50MHz),
    .reset     (reset),
    .clear     (phase_done),
    .tick      (tick)
  );

  // Durations are sampled only when the next phase is entered.
  always_comb begin
    state_nxt = state_e'(state_q + 2'd1);
    case (state_nxt)
      S_PV:    entry_len = max1(bus.Tpv);
      S_SV:    entry_len = max1(bus.Tsv);
      default: entry_len = max1(bus.Ta);
    endcase
  end

  assign ped_hit    = bus.pedReq && (state_q == S_PV) && (time_q > PED_MIN);
  assign phase_done = tick && (time_q == 7'd1);

  // Shortening takes priority over a coincident tick; the prescaler keeps running.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (ped_hit) begin
      time_d = PED_MIN;
    end else if (phase_done) begin
      state_d = state_nxt;
      time_d  = entry_len;
    end else if (tick) begin
      time_d = time_q - 7'd1;
    end
    lights_d = decode_lights(state_d);
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      state_q  <= S_PV;
      time_q   <= max1(bus.Tpv);
      lights_q <= decode_lights(S_PV);
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      lights_q <= lights_d;
    end
  end

  assign bus.timeRemaining        = time_q;
  assign bus.Principal_Road       = lights_q.prin_road;
  assign bus.Secondary_Road       = lights_q.sec_road;
  assign bus.Principal_Pedestrian = lights_q.prin_ped;
  assign bus.Secondary_Pedestrian = lights_q.sec_ped;
  assign bus.StateFlag            = state_q;
  assign bus.PhraseSel            = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Scoreboard bench for traffic_sequencer: per-cycle expected outputs plus scenario checks.
module tb_traffic_sequencer;
  import traffic_pkg::*;

  localparam int unsigned Cps    = 4;
  localparam logic [6:0]  PedMin = 7'd5;

  localparam logic [9:0] LPv = {3'b001, 3'b100, 2'b10, 2'b01};
  localparam logic [9:0] LPa = {3'b010, 3'b100, 2'b10, 2'b10};
  localparam logic [9:0] LSv = {3'b100, 3'b001, 2'b01, 2'b10};
  localparam logic [9:0] LSa = {3'b100, 3'b010, 2'b10, 2'b10};

  logic clock50MHz = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  traffic_sequencer_if bus_if ();

  traffic_sequencer #(
    .CLK_PER_SEC(Cps),
    .PED_MIN    (PedMin)
  ) dut (
    .clock50MHz(clock50MHz),
    .reset     (reset),
    .bus       (bus_if)
  );

  always #5 clock50MHz = ~clock50MHz;

  // Reference model: phase, seconds left and prescaler position.
  int         m_state = 0;
  int         m_pre = 0;
  logic [6:0] m_left = 7'd1;
  logic [20:0] exp_q[$];

  function automatic logic [9:0] lights_of(input int s);
    case (s)
      0:       return LPv;
      1:       return LPa;
      2:       return LSv;
      default: return LSa;
    endcase
  endfunction

  function automatic logic [6:0] len_of(input int s);
    logic [6:0] t;
    if (s == 0)      t = bus_if.Tpv;
    else if (s == 2) t = bus_if.Tsv;
    else             t = bus_if.Ta;
    return (t == 7'd0) ? 7'd1 : t;
  endfunction

  function automatic logic [9:0] act_lights();
    return {bus_if.Principal_Road, bus_if.Secondary_Road,
            bus_if.Principal_Pedestrian, bus_if.Secondary_Pedestrian};
  endfunction

  always @(posedge clock50MHz) begin : model
    int s, p;
    logic [6:0] l;
    logic [1:0] sc;
    logic tk;
    s = m_state;
    p = m_pre;
    l = m_left;
    if (reset) begin
      s = 0;
      p = 0;
      l = (bus_if.Tpv == 7'd0) ? 7'd1 : bus_if.Tpv;
    end else begin
      tk = (p == Cps - 1);
      if (bus_if.pedReq && s == 0 && l > PedMin) begin
        l = PedMin;
        p = tk ? 0 : p + 1;
      end else if (tk) begin
        p = 0;
        if (l == 7'd1) begin
          s = (s + 1) % 4;
          l = len_of(s);
        end else begin
          l = l - 7'd1;
        end
      end else begin
        p = p + 1;
      end
    end
    m_state <= s;
    m_pre   <= p;
    m_left  <= l;
    sc = 2'(s);
    exp_q.push_back({sc, sc, l, lights_of(s)});
  end

  // Advance one clock and compare the DUT against the oldest scoreboard entry.
  task automatic step();
    logic [20:0] e, a;
    @(negedge clock50MHz);
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: got no expected entry, required one per cycle");
    end else begin
      e = exp_q.pop_front();
      a = {bus_if.StateFlag, bus_if.PhraseSel, bus_if.timeRemaining, act_lights()};
      if (a !== e) $display("FAIL scoreboard @%0t: got %h required %h", $time, a, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.Tpv = 7'd10;
    bus_if.Tsv = 7'd8;
    bus_if.Ta  = 7'd3;
    bus_if.pedReq = 1'b0;
    step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.PhraseSel, bus_if.timeRemaining, act_lights()} !==
        {2'd0, 2'd0, 7'd10, LPv})
      $display("FAIL reset_state: got %h/%0d/%h required 0/10/%h",
               bus_if.StateFlag, bus_if.timeRemaining, act_lights(), LPv);
    else n_pass++;
    reset = 1'b0;
    repeat (3) step();
    n_checks++;
    if (bus_if.timeRemaining !== 7'd10)
      $display("FAIL hold_before_tick: got %0d required 10", bus_if.timeRemaining);
    else n_pass++;
    step();
    n_checks++;
    if (bus_if.timeRemaining !== 7'd9)
      $display("FAIL first_decrement: got %0d required 9", bus_if.timeRemaining);
    else n_pass++;
  endtask

  task automatic test_full_cycle();
    int lens[4] = '{36, 12, 32, 12};
    logic [1:0] nxt[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [6:0] tnxt[4] = '{7'd3, 7'd8, 7'd3, 7'd10};
    logic [9:0] lnxt[4] = '{LPa, LSv, LSa, LPv};
    logic viol;
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < lens[seg]; i++) begin
        step();
        viol = (bus_if.Secondary_Pedestrian == PED_GREEN && bus_if.Secondary_Road != LIGHT_RED) ||
               (bus_if.Principal_Pedestrian == PED_GREEN && bus_if.Principal_Road != LIGHT_RED) ||
               (bus_if.PhraseSel !== bus_if.StateFlag);
        n_checks++;
        if (viol) $display("FAIL ped_conflict_or_phrase: got lights %h phrase %0d flag %0d",
                           act_lights(), bus_if.PhraseSel, bus_if.StateFlag);
        else n_pass++;
      end
      n_checks++;
      if ({bus_if.StateFlag, bus_if.timeRemaining, act_lights()} !==
          {nxt[seg], tnxt[seg], lnxt[seg]})
        $display("FAIL phase_entry_%0d: got %0d/%0d/%h required %0d/%0d/%h", seg,
                 bus_if.StateFlag, bus_if.timeRemaining, act_lights(),
                 nxt[seg], tnxt[seg], lnxt[seg]);
      else n_pass++;
    end
  endtask

  task automatic test_short_phases();
    repeat (4) step();
    bus_if.Tpv = 7'd20;
    bus_if.Ta  = 7'd0;
    bus_if.Tsv = 7'd0;
    repeat (35) step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd0, 7'd1})
      $display("FAIL pv_unaffected: got %0d/%0d required 0/1",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
    step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd1, 7'd1})
      $display("FAIL pa_zero_len: got %0d/%0d required 1/1",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
    repeat (4) step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd2, 7'd1})
      $display("FAIL sv_zero_len: got %0d/%0d required 2/1",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
    repeat (8) step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd0, 7'd20})
      $display("FAIL pv_new_tpv: got %0d/%0d required 0/20",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
  endtask

  task automatic test_ped_request();
    repeat (44) step();
    bus_if.pedReq = 1'b1;
    step();
    bus_if.pedReq = 1'b0;
    n_checks++;
    if (bus_if.timeRemaining !== PedMin)
      $display("FAIL ped_shorten: got %0d required 5", bus_if.timeRemaining);
    else n_pass++;
    bus_if.Ta  = 7'd3;
    bus_if.Tsv = 7'd8;
    repeat (18) step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd0, 7'd1})
      $display("FAIL ped_pv_tail: got %0d/%0d required 0/1",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
    step();
    n_checks++;
    if (bus_if.StateFlag !== 2'd1)
      $display("FAIL ped_pa_after_20: got %0d required 1", bus_if.StateFlag);
    else n_pass++;
    bus_if.pedReq = 1'b1;
    repeat (13) step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd2, 7'd8})
      $display("FAIL ped_ignored_sv: got %0d/%0d required 2/8",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
    repeat (31) step();
    bus_if.pedReq = 1'b0;
    bus_if.Tpv = 7'd10;
    repeat (12) step();
    repeat (24) step();
    bus_if.pedReq = 1'b1;
    repeat (4) step();
    bus_if.pedReq = 1'b0;
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd0, 7'd3})
      $display("FAIL ped_ignored_low: got %0d/%0d required 0/3",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
  endtask

  task automatic test_ped_on_tick();
    repeat (68) step();
    repeat (7) step();
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining} !== {2'd0, 7'd9})
      $display("FAIL tick_setup: got %0d/%0d required 0/9",
               bus_if.StateFlag, bus_if.timeRemaining);
    else n_pass++;
    bus_if.pedReq = 1'b1;
    step();
    bus_if.pedReq = 1'b0;
    n_checks++;
    if (bus_if.timeRemaining !== 7'd5)
      $display("FAIL ped_on_tick: got %0d required 5", bus_if.timeRemaining);
    else n_pass++;
    repeat (4) step();
    n_checks++;
    if (bus_if.timeRemaining !== 7'd4)
      $display("FAIL after_ped_tick: got %0d required 4", bus_if.timeRemaining);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sa();
    repeat (60) step();
    n_checks++;
    if (bus_if.StateFlag !== 2'd3)
      $display("FAIL reach_sa: got %0d required 3", bus_if.StateFlag);
    else n_pass++;
    repeat (5) step();
    bus_if.Tpv = 7'd6;
    bus_if.pedReq = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.pedReq = 1'b0;
    n_checks++;
    if ({bus_if.StateFlag, bus_if.timeRemaining, act_lights()} !== {2'd0, 7'd6, LPv})
      $display("FAIL reset_mid_sa: got %0d/%0d/%h required 0/6/%h",
               bus_if.StateFlag, bus_if.timeRemaining, act_lights(), LPv);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (bus_if.timeRemaining !== 7'd6)
      $display("FAIL post_reset_hold: got %0d required 6", bus_if.timeRemaining);
    else n_pass++;
    step();
    n_checks++;
    if (bus_if.timeRemaining !== 7'd5)
      $display("FAIL post_reset_dec: got %0d required 5", bus_if.timeRemaining);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_short_phases();
    test_ped_request();
    test_ped_on_tick();
    test_reset_mid_sa();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
Name: traffic_sequencer

Overview:
- Traffic-light timing FSM for the two-road crossing with pedestrian heads.
- Sits directly upstream of the LCD output stage.
- Drives the road/pedestrian light buses, the seconds countdown, the phrase selector and the state flag consumed by that stage.
- Runs on the 50 MHz system clock with an internal one-second prescaler.

Parameters:
- CLK_PER_SEC, 50000000, clock cycles per second tick; set to 4 in simulation.
- PED_MIN, 7'd5, seconds of principal green left after a pedestrian request shortens the phase.

Ports:
- clock50MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- Tpv  in  7  principal green duration, seconds
- Tsv  in  7  secondary green duration, seconds
- Ta  in  7  amber duration, seconds (both roads)
- pedReq  in  1  pedestrian request on the principal crossing, level or pulse, already debounced
- timeRemaining  out  7  seconds left in the current phase
- Principal_Road  out  3  one-hot {red, amber, green}
- Secondary_Road  out  3  one-hot {red, amber, green}
- Principal_Pedestrian  out  2  one-hot {red, green}, crossing the principal road
- Secondary_Pedestrian  out  2  one-hot {red, green}, crossing the secondary road
- StateFlag  out  2  current state code
- PhraseSel  out  2  LCD phrase index, equal to StateFlag

Behaviour:
- Single clock domain. All outputs are registered and are decoded from the state and counter registers.
- States and codes:
  - S_PV=0: principal green, secondary red.
  - S_PA=1: principal amber, secondary red.
  - S_SV=2: secondary green, principal red.
  - S_SA=3: secondary amber, principal red.
- Transitions are cyclic: PV->PA->SV->SA->PV.
- Light decode:
  - Principal_Road: 001 in PV, 010 in PA, 100 in SV/SA.
  - Secondary_Road: 100 in PV/PA, 001 in SV, 010 in SA.
  - Secondary_Pedestrian = 01 (green) only in PV, else 10.
  - Principal_Pedestrian = 01 only in SV, else 10.
  - Pedestrian green never overlaps green or amber on the road it crosses.
- Prescaler: counter 0..CLK_PER_SEC-1; tick is asserted for one cycle when counter == CLK_PER_SEC-1, then the counter wraps to 0.
- Phase duration: on entry to a state, timeRemaining loads the state's duration, clamped by max(T,1):
  - PV uses Tpv, SV uses Tsv, PA/SA use Ta.
  - A value of 0 therefore gives a 1-second phase.
  - Inputs are sampled only at phase entry; changes mid-phase have no effect until the next entry.
- Countdown on tick:
  - If timeRemaining > 1: decrement by 1.
  - If timeRemaining == 1: move to the next state, load the new duration, and reset the prescaler to 0.
  - Every phase lasts exactly N full ticks. timeRemaining is never 0 after reset.
- Reset, synchronous, also mid-phase:
  - state = S_PV, prescaler = 0, timeRemaining = max(Tpv,1) sampled on the reset edge.
  - Outputs: Principal_Road=001, Secondary_Road=100, Principal_Pedestrian=10, Secondary_Pedestrian=01, StateFlag=0, PhraseSel=0.
  - Reset wins over tick and pedReq.
- Pedestrian request:
  - Condition: pedReq high in S_PV and timeRemaining > PED_MIN, on a non-tick cycle.
  - Action: next cycle timeRemaining = PED_MIN and the prescaler is unchanged.
  - If the request coincides with a tick, the shortening wins and the decrement is skipped for that tick.
  - pedReq is ignored in all other states, or when timeRemaining <= PED_MIN. It is not latched.
- Width: all time arithmetic is 7-bit unsigned; the maximum phase is 127 s. No overflow paths exist.

Decomposition:
- Package traffic_pkg:
  - state codes S_PV..S_SA.
  - light constants: LIGHT_RED=3'b100, LIGHT_AMBER=3'b010, LIGHT_GREEN=3'b001, PED_RED=2'b10, PED_GREEN=2'b01.
  - phase duration function max1(T).
- One sub-module: second_tick_gen, holding the prescaler.
  - Parameter CLK_PER_SEC.
  - Ports: clock50MHz, reset, clear, tick.
  - clear is driven on phase transitions.

Test Plan (CLK_PER_SEC=4, PED_MIN=5):
- Reset with Tpv=10, Tsv=8, Ta=3 -> PV, timeRemaining=10; decrements every 4 cycles. Phase sequence: PV 10 s (40 cycles), PA 3 s, SV 8 s, SA 3 s, then back to PV; full cycle = 96 cycles.
- Light/pedestrian decode across one full cycle -> exact one-hot values per state. Checker asserts there is never a pedestrian green together with green or amber on the crossed road, and PhraseSel==StateFlag throughout.
- Ta=0, Tsv=0 -> PA and SV each last exactly 4 cycles with timeRemaining=1. Change Tpv from 10 to 20 mid-PV -> the current phase is unaffected and the next PV loads 20.
- pedReq pulse in PV at timeRemaining=9 -> timeRemaining=5 next cycle, PA follows 20 cycles later. pedReq at timeRemaining=4, or in SV -> no effect.
- pedReq on a tick cycle at timeRemaining=9 -> 5, not 8.
- Reset asserted mid-SA with Tpv=6 -> next edge: PV, timeRemaining=6, prescaler 0. First decrement follows 4 cycles after reset deassertion.
